// File: rtl/rng_pkg.sv
// Shared types and helpers for the multi-channel RNG stream controller.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rng_state_e;

    localparam logic MODE_XOR = 1'b0;
    localparam logic MODE_CAT = 1'b1;

    // Ceiling division of a byte count into whole stream words; 33-bit sum avoids wrap near 2^32.
    function automatic logic [31:0] words_from_bytes(input logic [31:0] bytes,
                                                     input int unsigned bytes_per_word);
        logic [32:0] sum;
        sum = {1'b0, bytes} + 33'(bytes_per_word - 1);
        return 32'(sum / 33'(bytes_per_word));
    endfunction

endpackage

// File: rtl/rng_sfifo.sv
// Synchronous first-word fall-through FIFO; the MSB of each entry carries TLAST and can be
// set after the fact on the newest entry so an aborted transfer still terminates its packet.
module rng_sfifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             set_last,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_d = count + CW'(do_push) - CW'(do_pop);
    end

    // Storage carries no reset; validity is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
        if (set_last && !empty) begin
            mem[wr_ptr - AW'(1)][WIDTH-1] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/rng_stream_ctrl.sv
// Combines NUM_CH entropy channels into DATA_W-bit words and streams them over AXI-Stream.
// Define RNG_STATS_EN to build the saturating ones-count statistic on RNG_STATS.
module rng_stream_ctrl
    import rng_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned BURST_WORDS = 64
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [NUM_CH-1:0] ENT_BIT,
    input  logic [NUM_CH-1:0] ENT_VALID,
    input  logic              RNG_GO,
    input  logic              RNG_STOP,
    input  logic              RNG_MODE,
    input  logic [NUM_CH-1:0] RNG_CH_MASK,
    input  logic [31:0]       RNG_SEND_BYTES,
    output logic              RNG_RUN,
    output logic              RNG_OVER,
    output logic [31:0]       RNG_SENT_BYTES,
    output logic [31:0]       RNG_STATS,
    output logic [DATA_W-1:0] AXIS_TDATA,
    output logic              AXIS_TLAST,
    output logic              AXIS_TVALID,
    input  logic              AXIS_TREADY
);

    localparam int unsigned BPW     = DATA_W / 8;
    localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
    localparam int unsigned BURST_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

    rng_state_e         state_q, state_d;
    logic               mode_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [31:0]        target_q;
    logic [31:0]        pushed_q;
    logic [BURST_W-1:0] burst_q;
    logic [DATA_W-1:0]  pack_q, pack_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic               run_q;
    logic               over_q;
    logic [31:0]        sent_q;

    logic [NUM_CH-1:0]  mask_eff_c;
    logic               go_c, stop_c, sample_c, word_done_c;
    logic               push_c, drop_c, handshake_c;
    logic               last_target_c, last_burst_c;
    logic               fifo_full, fifo_empty;
    logic [DATA_W:0]    fifo_rdata;

    assign go_c          = RNG_GO && (state_q == IDLE);
    assign stop_c        = RNG_STOP && (state_q == RUN);
    assign mask_eff_c    = (mode_q == MODE_CAT) ? '1 : mask_q;
    // A sample needs every enabled channel valid; STOP in the same cycle discards it.
    assign sample_c      = (state_q == RUN) && !RNG_STOP && (mask_eff_c != '0)
                           && (&(ENT_VALID | ~mask_eff_c));
    assign word_done_c   = sample_c && (fill_d == CNT_W'(DATA_W));
    assign push_c        = word_done_c && !fifo_full;
    assign drop_c        = word_done_c && fifo_full;
    assign handshake_c   = AXIS_TVALID && AXIS_TREADY;
    assign last_target_c = (target_q != '0) && ((pushed_q + 32'd1) == target_q);
    assign last_burst_c  = (burst_q == BURST_W'(BURST_WORDS - 1));

    // New bits enter at the MSB and shift down, so the first sample ends up in bit 0.
    always_comb begin
        pack_d = pack_q;
        fill_d = fill_q;
        if (mode_q == MODE_CAT) begin
            pack_d = {ENT_BIT, pack_q[DATA_W-1:NUM_CH]};
            fill_d = fill_q + CNT_W'(NUM_CH);
        end else begin
            pack_d = {^(ENT_BIT & mask_q), pack_q[DATA_W-1:1]};
            fill_d = fill_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (RNG_GO) state_d = RUN;
            RUN:     if (RNG_STOP || (push_c && last_target_c)) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run_q    <= 1'b0;
            mode_q   <= MODE_XOR;
            mask_q   <= '0;
            target_q <= '0;
            pushed_q <= '0;
            burst_q  <= '0;
            pack_q   <= '0;
            fill_q   <= '0;
            over_q   <= 1'b0;
            sent_q   <= '0;
        end else begin
            run_q <= (state_d != IDLE);
            if (go_c) begin
                mode_q   <= RNG_MODE;
                mask_q   <= RNG_CH_MASK;
                target_q <= words_from_bytes(RNG_SEND_BYTES, BPW);
                pushed_q <= '0;
                burst_q  <= '0;
                pack_q   <= '0;
                fill_q   <= '0;
                over_q   <= 1'b0;
                sent_q   <= '0;
            end else begin
                if (stop_c) begin
                    pack_q <= '0;
                    fill_q <= '0;
                end else if (sample_c) begin
                    pack_q <= pack_d;
                    fill_q <= word_done_c ? '0 : fill_d;
                end
                if (push_c) begin
                    pushed_q <= pushed_q + 32'd1;
                    burst_q  <= last_burst_c ? '0 : burst_q + BURST_W'(1);
                end
                if (drop_c)      over_q <= 1'b1;
                if (handshake_c) sent_q <= sent_q + 32'(BPW);
            end
        end
    end

    rng_sfifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .push     (push_c),
        .wdata    ({last_target_c | last_burst_c, pack_d}),
        .pop      (AXIS_TREADY),
        .set_last (stop_c),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign AXIS_TDATA     = fifo_rdata[DATA_W-1:0];
    assign AXIS_TLAST     = fifo_rdata[DATA_W];
    assign AXIS_TVALID    = ~fifo_empty;
    assign RNG_RUN        = run_q;
    assign RNG_OVER       = over_q;
    assign RNG_SENT_BYTES = sent_q;

`ifdef RNG_STATS_EN
    localparam int unsigned ONES_W = $clog2(DATA_W + 1);
    logic [ONES_W-1:0] ones_c;
    logic [32:0]       stats_sum_c;
    logic [31:0]       stats_q;

    always_comb begin
        ones_c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ones_c = ones_c + ONES_W'(pack_d[i]);
        end
        stats_sum_c = {1'b0, stats_q} + 33'(ones_c);
    end

    // Saturating ones count over every word that enters the FIFO.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            stats_q <= '0;
        end else if (go_c) begin
            stats_q <= '0;
        end else if (push_c) begin
            stats_q <= stats_sum_c[32] ? 32'hFFFF_FFFF : stats_sum_c[31:0];
        end
    end

    assign RNG_STATS = stats_q;
`else
    assign RNG_STATS = '0;
`endif

endmodule

// File: tb/tb_rng_stream_ctrl.sv
// Directed bench for rng_stream_ctrl (NUM_CH=4, DATA_W=32, FIFO_DEPTH=16, BURST_WORDS=4).
module tb_rng_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ent_bit, ent_valid, ch_mask;
    logic        go, stop, mode, tready;
    logic [31:0] send_bytes;
    logic        run, over, tlast, tvalid;
    logic [31:0] sent, stats, tdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];

    always #5 clk = ~clk;

    rng_stream_ctrl #(
        .NUM_CH(4), .DATA_W(32), .FIFO_DEPTH(16), .BURST_WORDS(4)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n), .ENT_BIT(ent_bit), .ENT_VALID(ent_valid),
        .RNG_GO(go), .RNG_STOP(stop), .RNG_MODE(mode), .RNG_CH_MASK(ch_mask),
        .RNG_SEND_BYTES(send_bytes), .RNG_RUN(run), .RNG_OVER(over),
        .RNG_SENT_BYTES(sent), .RNG_STATS(stats), .AXIS_TDATA(tdata),
        .AXIS_TLAST(tlast), .AXIS_TVALID(tvalid), .AXIS_TREADY(tready)
    );

    // Record every accepted beat.
    always @(posedge clk) begin
        if (tvalid && tready) begin
            q_data.push_back(tdata);
            q_last.push_back(tlast);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic m, input logic [3:0] msk, input logic [31:0] bytes);
        mode = m; ch_mask = msk; send_bytes = bytes; go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (!run) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (run !== 1'b0)    begin bad++; $display("FAIL reset_run got=%b want=0", run); end
        total++; if (over !== 1'b0)   begin bad++; $display("FAIL reset_over got=%b want=0", over); end
        total++; if (sent !== 32'd0)  begin bad++; $display("FAIL reset_sent got=%h want=0", sent); end
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", tvalid); end
        total++; if (tlast !== 1'b0)  begin bad++; $display("FAIL reset_tlast got=%b want=0", tlast); end
        total++; if (tdata !== 32'd0) begin bad++; $display("FAIL reset_tdata got=%h want=0", tdata); end
        total++; if (stats !== 32'd0) begin bad++; $display("FAIL reset_stats got=%h want=0", stats); end
    endtask

    // XOR mode: bit k of the stream is 1 when k%3==0.
    task automatic test_xor();
        int base;
        bit to;
        logic [31:0] exp_w[2];
        exp_w[0] = 32'h4924_9249;
        exp_w[1] = 32'h9249_2492;
        base = q_data.size();
        tready = 1'b1;
        start(1'b0, 4'hF, 32'd8);
        for (int k = 0; k < 64; k++) begin
            ent_valid = 4'hF;
            ent_bit   = ((k % 3) == 0) ? 4'b0001 : 4'b0000;
            tick();
            if (k == 30) begin
                total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL xor_early_valid got=%b want=0", tvalid); end
            end
            if (k == 31) begin
                total++; if (tvalid !== 1'b1 || tdata !== exp_w[0]) begin
                    bad++; $display("FAIL xor_latency valid=%b data=%h want valid=1 data=%h", tvalid, tdata, exp_w[0]);
                end
            end
        end
        ent_valid = 4'h0;
        wait_idle(50, to);
        total++; if (to) begin bad++; $display("FAIL xor_idle_timeout run=%b want=0", run); end
        total++; if (q_data.size() - base != 2) begin
            bad++; $display("FAIL xor_count got=%0d want=2", q_data.size() - base);
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++; if (q_data[base+i] !== exp_w[i] || q_last[base+i] !== (i == 1)) begin
                    bad++; $display("FAIL xor_word%0d data=%h last=%b want data=%h last=%b",
                                    i, q_data[base+i], q_last[base+i], exp_w[i], (i == 1));
                end
            end
        end
        total++; if (sent !== 32'd8) begin bad++; $display("FAIL xor_sent got=%0d want=8", sent); end
    endtask

    // Concatenate mode, 5 bytes rounds up to 2 words; mask is ignored.
    task automatic test_cat();
        int base;
        bit to;
        base = q_data.size();
        tready = 1'b1;
        start(1'b1, 4'h0, 32'd5);
        for (int k = 0; k < 16; k++) begin
            ent_valid = 4'hF; ent_bit = 4'b1010;
            tick();
            if (k == 7) begin
                total++; if (tvalid !== 1'b1 || tdata !== 32'hAAAA_AAAA) begin
                    bad++; $display("FAIL cat_first valid=%b data=%h want valid=1 data=aaaaaaaa", tvalid, tdata);
                end
            end
        end
        ent_valid = 4'h0;
        wait_idle(50, to);
        total++; if (to) begin bad++; $display("FAIL cat_idle_timeout run=%b want=0", run); end
        total++; if (q_data.size() - base != 2) begin
            bad++; $display("FAIL cat_count got=%0d want=2", q_data.size() - base);
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++; if (q_data[base+i] !== 32'hAAAA_AAAA || q_last[base+i] !== (i == 1)) begin
                    bad++; $display("FAIL cat_word%0d data=%h last=%b want data=aaaaaaaa last=%b",
                                    i, q_data[base+i], q_last[base+i], (i == 1));
                end
            end
        end
        total++; if (sent !== 32'd8) begin bad++; $display("FAIL cat_sent got=%0d want=8", sent); end
    endtask

    // XOR mode with an empty mask never samples; only STOP ends the run.
    task automatic test_mask_zero();
        int base;
        bit to;
        base = q_data.size();
        start(1'b0, 4'h0, 32'd4);
        for (int k = 0; k < 40; k++) begin
            ent_valid = 4'hF; ent_bit = 4'hF;
            tick();
        end
        ent_valid = 4'h0;
        total++; if (run !== 1'b1 || tvalid !== 1'b0) begin
            bad++; $display("FAIL mask0_running run=%b tvalid=%b want run=1 tvalid=0", run, tvalid);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(20, to);
        total++; if (to) begin bad++; $display("FAIL mask0_idle_timeout run=%b want=0", run); end
        total++; if (q_data.size() != base) begin
            bad++; $display("FAIL mask0_count got=%0d want=0", q_data.size() - base);
        end
    endtask

    // Stalled sink: 16 words fill the FIFO, later words drop and raise OVER.
    task automatic test_overrun();
        int base;
        int unstable;
        bit to;
        logic [3:0]  nib;
        logic [31:0] exp_d;
        unstable = 0;
        base = q_data.size();
        tready = 1'b0;
        start(1'b1, 4'hF, 32'd0);
        for (int c = 0; c < 200; c++) begin
            ent_valid = 4'hF; ent_bit = 4'(c / 8);
            tick();
            if (c >= 7 && (tvalid !== 1'b1 || tdata !== 32'd0 || tlast !== 1'b0)) unstable++;
        end
        ent_valid = 4'h0;
        total++; if (over !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", over); end
        total++; if (unstable != 0) begin bad++; $display("FAIL ovr_stall_stable unstable_cycles=%0d want=0", unstable); end
        stop = 1'b1; tick(); stop = 1'b0;
        tready = 1'b1;
        wait_idle(100, to);
        total++; if (to) begin bad++; $display("FAIL ovr_idle_timeout run=%b want=0", run); end
        total++; if (q_data.size() - base != 16) begin
            bad++; $display("FAIL ovr_count got=%0d want=16", q_data.size() - base);
        end else begin
            for (int w = 0; w < 16; w++) begin
                nib = 4'(w);
                exp_d = {8{nib}};
                total++; if (q_data[base+w] !== exp_d || q_last[base+w] !== ((w % 4) == 3)) begin
                    bad++; $display("FAIL ovr_word%0d data=%h last=%b want data=%h last=%b",
                                    w, q_data[base+w], q_last[base+w], exp_d, ((w % 4) == 3));
                end
            end
        end
        total++; if (over !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", over); end
    endtask

    // 40 bytes = 10 words, bursts of 4: TLAST on words 4, 8 and 10.
    task automatic test_burst();
        int base;
        bit to;
        logic [3:0]  nib;
        logic [31:0] exp_d;
        bit          exp_l;
        base = q_data.size();
        tready = 1'b1;
        start(1'b1, 4'hF, 32'd40);
        for (int c = 0; c < 96; c++) begin
            ent_valid = 4'hF; ent_bit = 4'((c / 8) + 1);
            tick();
        end
        ent_valid = 4'h0;
        wait_idle(50, to);
        total++; if (to) begin bad++; $display("FAIL burst_idle_timeout run=%b want=0", run); end
        total++; if (q_data.size() - base != 10) begin
            bad++; $display("FAIL burst_count got=%0d want=10", q_data.size() - base);
        end else begin
            for (int w = 0; w < 10; w++) begin
                nib = 4'(w + 1);
                exp_d = {8{nib}};
                exp_l = (w == 3) || (w == 7) || (w == 9);
                total++; if (q_data[base+w] !== exp_d || q_last[base+w] !== exp_l) begin
                    bad++; $display("FAIL burst_word%0d data=%h last=%b want data=%h last=%b",
                                    w, q_data[base+w], q_last[base+w], exp_d, exp_l);
                end
            end
        end
        total++; if (sent !== 32'd40) begin bad++; $display("FAIL burst_sent got=%0d want=40", sent); end
        total++; if (over !== 1'b0) begin bad++; $display("FAIL burst_over got=%b want=0", over); end
    endtask

    // STOP after 1.5 words: half word discarded, queued word gains TLAST.
    task automatic test_stop();
        int base;
        bit to;
        base = q_data.size();
        tready = 1'b0;
        start(1'b1, 4'hF, 32'd0);
        for (int c = 0; c < 12; c++) begin
            ent_valid = 4'hF; ent_bit = (c < 8) ? 4'h5 : 4'h3;
            tick();
        end
        stop = 1'b1; ent_valid = 4'hF; ent_bit = 4'h3;
        tick();
        stop = 1'b0; ent_valid = 4'h0;
        total++; if (tvalid !== 1'b1 || tlast !== 1'b1 || tdata !== 32'h5555_5555) begin
            bad++; $display("FAIL stop_head valid=%b last=%b data=%h want valid=1 last=1 data=55555555",
                            tvalid, tlast, tdata);
        end
        tready = 1'b1;
        wait_idle(30, to);
        total++; if (to) begin bad++; $display("FAIL stop_idle_timeout run=%b want=0", run); end
        repeat (5) tick();
        total++; if (q_data.size() - base != 1) begin
            bad++; $display("FAIL stop_count got=%0d want=1", q_data.size() - base);
        end else begin
            total++; if (q_data[base] !== 32'h5555_5555 || q_last[base] !== 1'b1) begin
                bad++; $display("FAIL stop_word data=%h last=%b want data=55555555 last=1", q_data[base], q_last[base]);
            end
        end
    endtask

    task automatic test_stats();
        int base;
        bit to;
        logic [31:0] exp_stats;
`ifdef RNG_STATS_EN
        exp_stats = 32'd8;
`else
        exp_stats = 32'd0;
`endif
        base = q_data.size();
        tready = 1'b1;
        start(1'b1, 4'hF, 32'd4);
        for (int c = 0; c < 8; c++) begin
            ent_valid = 4'hF; ent_bit = 4'b0001;
            tick();
        end
        ent_valid = 4'h0;
        wait_idle(30, to);
        total++; if (to) begin bad++; $display("FAIL stats_idle_timeout run=%b want=0", run); end
        total++; if (q_data.size() - base != 1) begin
            bad++; $display("FAIL stats_count got=%0d want=1", q_data.size() - base);
        end else begin
            total++; if (q_data[base] !== 32'h1111_1111 || q_last[base] !== 1'b1) begin
                bad++; $display("FAIL stats_word data=%h last=%b want data=11111111 last=1", q_data[base], q_last[base]);
            end
        end
        total++; if (stats !== exp_stats) begin bad++; $display("FAIL stats_value got=%0d want=%0d", stats, exp_stats); end
        total++; if (sent !== 32'd4) begin bad++; $display("FAIL stats_sent got=%0d want=4", sent); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ent_bit = '0; ent_valid = '0; ch_mask = '0;
        go = 1'b0; stop = 1'b0; mode = 1'b0; tready = 1'b0; send_bytes = '0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_xor();
        test_cat();
        test_mask_zero();
        test_overrun();
        test_burst();
        test_stop();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_stream_ctrl.md
Name: rng_stream_ctrl

Overview:
- Parametrised successor to the single-source RNG core. It collects raw bits from NUM_CH entropy channels and combines them by mode.
- Combined bits are packed into DATA_W-bit words, buffered in a FIFO and sent on an AXI-Stream master. TLAST is placed at burst and transfer boundaries.
- Exposes GO/STOP/RUN/OVER and byte counters for the AXI-Lite control block; sits between the entropy sources and the DMA.

Parameters:
- NUM_CH, 4: number of entropy channels (1..8).
- DATA_W, 32: stream word width (32 or 64; must be a multiple of NUM_CH).
- FIFO_DEPTH, 16: output FIFO depth in words (power of 2, >= 4).
- BURST_WORDS, 64: words per TLAST burst (>= 1).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- ENT_BIT  in  NUM_CH  raw bit per channel
- ENT_VALID  in  NUM_CH  per-channel bit strobe
- RNG_GO  in  1  one-cycle start pulse
- RNG_STOP  in  1  one-cycle abort pulse
- RNG_MODE  in  1  0 = XOR combine, 1 = concatenate; sampled on GO
- RNG_CH_MASK  in  NUM_CH  enabled channels; sampled on GO
- RNG_SEND_BYTES  in  32  transfer length in bytes; 0 = unlimited; sampled on GO
- RNG_RUN  out  1  high while not IDLE
- RNG_OVER  out  1  sticky overrun flag
- RNG_SENT_BYTES  out  32  bytes accepted by the sink
- RNG_STATS  out  32  ones count (optional feature)
- AXIS_TDATA  out  DATA_W  stream data
- AXIS_TLAST  out  1  burst/transfer end
- AXIS_TVALID  out  1  stream valid
- AXIS_TREADY  in  1  stream ready

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; packer empty; counters 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on GO. GO clears SENT_BYTES, OVER, STATS and the packer. Target words = ceil(SEND_BYTES / (DATA_W/8)).
  - RUN -> DRAIN when the target count of words has been pushed, or on STOP.
  - DRAIN -> IDLE when the FIFO is empty and the final word has handshaken.
  - GO outside IDLE is ignored. STOP in IDLE or DRAIN is ignored.
- Sample event (RUN only): occurs in a cycle where every masked channel has ENT_VALID=1.
  - Mode 0: appends 1 bit, the XOR of ENT_BIT over the mask.
  - Mode 1: appends NUM_CH bits (ENT_BIT, LSB first); the mask is forced to all ones.
  - A mask of 0 in mode 0 produces no samples; RUN stays high until STOP.
- Packing: bits fill from the LSB.
  - A word completes when DATA_W bits are collected and is pushed the same cycle.
  - Packing latency to TVALID: 1 cycle after the completing sample.
- Overrun: a completed word arriving with the FIFO full is dropped; OVER is set and held until the next GO. A dropped word does not count toward the target.
- STOP: any partial packer word is discarded. Words already in the FIFO still drain.
- AXI-Stream: TDATA/TLAST are stable while TVALID=1 and TREADY=0. TVALID is never withdrawn without a handshake.
- SENT_BYTES += DATA_W/8 per handshake; wraps modulo 2^32.
- TLAST is set on the word whose pushed index satisfies either:
  - it is the last word of the target, or
  - (index+1) mod BURST_WORDS == 0.
  - On STOP, the most recently pushed word still in the FIFO gets TLAST. If the FIFO is empty at STOP, no extra word is emitted.
- A simultaneous sample and STOP in the same cycle: STOP wins and the sample is discarded.
- ARESETN asserted mid-transfer aborts immediately; FIFO contents are lost.

Optional Feature:
- RNG_STATS_EN defined:
  - RNG_STATS counts ones in every pushed word, saturating at 0xFFFFFFFF.
  - Cleared on GO.
- Not defined: RNG_STATS is tied to 0 and no counter logic is generated.

Decomposition:
- Package rng_pkg holds:
  - FSM state enum (IDLE/RUN/DRAIN)
  - mode constants MODE_XOR=0, MODE_CAT=1
  - a function computing words from bytes (ceil division)
- One sub-module, rng_sfifo: synchronous FIFO of width DATA_W+1 (TLAST bit appended) with full/empty flags and first-word fall-through output.

Test Plan:
- NUM_CH=4, DATA_W=32, mode 0, mask 4'b1111, SEND_BYTES=8, all channels valid every cycle, TREADY=1 -> exactly 2 words after 32 and 64 samples; TLAST on word 2; SENT_BYTES=8; RUN falls after the last handshake.
- Mode 1, SEND_BYTES=5 -> target 2 words (ceil), each filled after 8 sample cycles; ENT_BIT=4'b1010 constant -> TDATA=0xAAAAAAAA.
- TREADY=0 for 200 cycles, SEND_BYTES=0, mode 1 -> FIFO fills with 16 words, OVER=1; after TREADY=1, exactly 16 words stream out with TVALID/TDATA stable during the stall.
- BURST_WORDS=4, SEND_BYTES=40 -> TLAST on words 4, 8 and 10 only.
- STOP pulsed after 1.5 words, with word 1 still in the FIFO (TREADY=0) -> partial word discarded; word 1 emitted with TLAST=1; state returns to IDLE.
- With RNG_STATS_EN, mode 1, ENT_BIT=4'b0001, SEND_BYTES=4 -> RNG_STATS=8. Without the macro -> RNG_STATS=0.
